// File: rtl/ula_seq_pkg.sv
// ula_seq_pkg: shared types and constants for the ULA sequencer.
//   state_t    - sequencer FSM states (IDLE, EXEC, RESP)
//   FLG_*      - bit positions of O/C/S/Z inside a 4-bit flag word
//   OP_W       - ULA opcode width
//   pack_flags - assembles {O,C,S,Z} from the individual ULA flag lines
package ula_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLG_O = 3;
    localparam int FLG_C = 2;
    localparam int FLG_S = 1;
    localparam int FLG_Z = 0;
    localparam int NFLG  = 4;
    localparam int OP_W  = 5;

    function automatic logic [NFLG-1:0] pack_flags(input logic o, input logic c,
                                                   input logic s, input logic z);
        logic [NFLG-1:0] f;
        f        = '0;
        f[FLG_O] = o;
        f[FLG_C] = c;
        f[FLG_S] = s;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst  - clock, async active-high reset
//   req[1:0]  - request lines
//   advance   - commit the current grant (updates last-grant pointer)
//   grant     - one-hot grant, combinational from req and pointer
// The pointer remembers the last winner; on a tie the other input wins.
// It resets to 1 so input 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (advance && (|grant))
            last <= grant[1];
    end

endmodule

// File: rtl/ula_seq.sv
// ula_seq: shares one combinational ULA between two requesters.
//   clk, rst                 - clock, async active-high reset
//   req{0,1}_valid/ready     - request handshake (ready is combinational, IDLE only)
//   req{0,1}_a/b/op/setf     - operands, opcode, flag-register update enable
//   ula_a/b/op               - operand registers driven to the external ULA
//   ula_resu, ula_o/c/s/z    - ULA result and flags (combinational)
//   rsp_valid/ready          - response handshake
//   rsp_id/data/flags        - requester id, registered result, {O,C,S,Z}
//   flags                    - architectural flag register {O,C,S,Z}
// Flow: IDLE (grant+latch) -> EXEC (ULA evaluates, result captured) -> RESP
// (held until rsp_ready). One operation in flight at a time.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [BITS-1:0] req0_a,
    input  logic [BITS-1:0] req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req0_setf,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [BITS-1:0] req1_a,
    input  logic [BITS-1:0] req1_b,
    input  logic [OP_W-1:0] req1_op,
    input  logic            req1_setf,
    output logic [BITS-1:0] ula_a,
    output logic [BITS-1:0] ula_b,
    output logic [OP_W-1:0] ula_op,
    input  logic [BITS-1:0] ula_resu,
    input  logic            ula_o,
    input  logic            ula_c,
    input  logic            ula_s,
    input  logic            ula_z,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [BITS-1:0] rsp_data,
    output logic [NFLG-1:0] rsp_flags,
    output logic [NFLG-1:0] flags
);

    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [OP_W-1:0] op;
        logic            setf;
    } req_t;

    state_t          state, state_nxt;
    req_t [1:0]      req_in;
    logic [1:0]      req_v;
    logic [1:0]      grant;
    logic            idle;
    logic            accept;
    req_t            opr;
    logic            opr_id;
    logic [NFLG-1:0] ula_flags;

    assign req_in[0] = '{a: req0_a, b: req0_b, op: req0_op, setf: req0_setf};
    assign req_in[1] = '{a: req1_a, b: req1_b, op: req1_op, setf: req1_setf};
    assign req_v     = {req1_valid, req0_valid};

    assign idle   = (state == IDLE);
    assign accept = idle && (|grant);

    // Pointer only moves when a grant is actually taken (IDLE).
    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_v),
        .advance (idle),
        .grant   (grant)
    );

    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers feed the ULA continuously and keep their value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opr    <= '0;
            opr_id <= 1'b0;
        end else if (accept) begin
            opr    <= grant[1] ? req_in[1] : req_in[0];
            opr_id <= grant[1];
        end
    end

    assign ula_a  = opr.a;
    assign ula_b  = opr.b;
    assign ula_op = opr.op;

    assign ula_flags = pack_flags(ula_o, ula_c, ula_s, ula_z);

    // Result capture at the end of the single EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_id    <= 1'b0;
            flags     <= '0;
        end else if (state == EXEC) begin
            rsp_data  <= ula_resu;
            rsp_flags <= ula_flags;
            rsp_id    <= opr_id;
            if (opr.setf)
                flags <= ula_flags;
        end
    end

    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_ula_seq.sv
module tb_ula_seq;
    localparam int BITS = 16;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_XOR = 5'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [BITS-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [4:0]      req0_op = '0, req1_op = '0;
    logic            req0_setf = 1'b0, req1_setf = 1'b0;
    logic [BITS-1:0] ula_a, ula_b, ula_resu;
    logic [4:0]      ula_op;
    logic            ula_o, ula_c, ula_s, ula_z;
    logic            rsp_valid, rsp_id;
    logic            rsp_ready = 1'b0;
    logic [BITS-1:0] rsp_data;
    logic [3:0]      rsp_flags, flags;

    int errs = 0;
    int nchk = 0;

    // Model state: last granted port and architectural flags.
    logic       m_last = 1'b1;
    logic [3:0] m_freg = 4'h0;

    always #5 clk = ~clk;

    ula_seq #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_setf(req0_setf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_setf(req1_setf),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_resu(ula_resu),
        .ula_o(ula_o), .ula_c(ula_c), .ula_s(ula_s), .ula_z(ula_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flags(flags)
    );

    // External ULA stand-in (bit-level, combinational).
    logic [BITS:0] ula_w;
    always_comb begin
        ula_w = '0;
        ula_o = 1'b0;
        ula_c = 1'b0;
        case (ula_op)
            OP_ADD: begin
                ula_w = {1'b0, ula_a} + {1'b0, ula_b};
                ula_o = (ula_a[BITS-1] == ula_b[BITS-1]) && (ula_w[BITS-1] != ula_a[BITS-1]);
                ula_c = ula_w[BITS];
            end
            OP_SUB: begin
                ula_w = {1'b0, ula_a} - {1'b0, ula_b};
                ula_o = (ula_a[BITS-1] != ula_b[BITS-1]) && (ula_w[BITS-1] != ula_a[BITS-1]);
                ula_c = ula_w[BITS];
            end
            OP_AND:  ula_w = {1'b0, ula_a & ula_b};
            default: ula_w = {1'b0, ula_a ^ ula_b};
        endcase
    end
    assign ula_resu = ula_w[BITS-1:0];
    assign ula_s    = ula_resu[BITS-1];
    assign ula_z    = (ula_resu == '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on integers; flags are {O,C,S,Z}.
    function automatic void ref_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] d, output logic [3:0] f);
        int sa = $signed(a);
        int sb = $signed(b);
        int ua = int'(a);
        int ub = int'(b);
        int r;
        logic o, c;
        o = 1'b0;
        c = 1'b0;
        case (op)
            OP_ADD: begin r = sa + sb; o = (r > 32767) || (r < -32768); c = (ua + ub) > 65535; end
            OP_SUB: begin r = sa - sb; o = (r > 32767) || (r < -32768); c = ua < ub; end
            OP_AND: r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        d = r[15:0];
        f = {o, c, d[15], d == 16'h0};
    endfunction

    // One full transaction; entered just after a negedge with the DUT idle.
    task automatic send(input logic v0, input logic v1,
                        input logic [15:0] a0, input logic [15:0] b0, input logic [4:0] op0, input logic s0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic [4:0] op1, input logic s1,
                        input int bp, input logic eid, input logic [15:0] ed,
                        input logic [3:0] erf, input logic [3:0] efr, input string tag);
        logic [15:0] ea, eb;
        logic [4:0]  eop;
        ea  = eid ? a1 : a0;
        eb  = eid ? b1 : b0;
        eop = eid ? op1 : op0;
        req0_a = a0; req0_b = b0; req0_op = op0; req0_setf = s0;
        req1_a = a1; req1_b = b1; req1_op = op1; req1_setf = s1;
        req0_valid = v0; req1_valid = v1;
        rsp_ready  = (bp == 0);
        #1;
        chk({tag, " ready0"}, 32'(req0_ready), 32'(!eid));
        chk({tag, " ready1"}, 32'(req1_ready), 32'(eid));
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk({tag, " ula_a"}, 32'(ula_a), 32'(ea));
        chk({tag, " ula_b"}, 32'(ula_b), 32'(eb));
        chk({tag, " ula_op"}, 32'(ula_op), 32'(eop));
        chk({tag, " rsp_valid T+1"}, 32'(rsp_valid), 0);
        @(negedge clk);
        chk({tag, " rsp_valid T+2"}, 32'(rsp_valid), 1);
        chk({tag, " rsp_id"}, 32'(rsp_id), 32'(eid));
        chk({tag, " rsp_data"}, 32'(rsp_data), 32'(ed));
        chk({tag, " rsp_flags"}, 32'(rsp_flags), 32'(erf));
        chk({tag, " flags"}, 32'(flags), 32'(efr));
        if (bp > 0) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk({tag, " bp valid"}, 32'(rsp_valid), 1);
                chk({tag, " bp data"}, 32'(rsp_data), 32'(ed));
                chk({tag, " bp id"}, 32'(rsp_id), 32'(eid));
                chk({tag, " bp readys"}, 32'({req1_ready, req0_ready}), 0);
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
            rsp_ready  = 1'b1;
        end
        @(negedge clk);
        chk({tag, " back idle"}, 32'(rsp_valid), 0);
        chk({tag, " ula_a hold"}, 32'(ula_a), 32'(ea));
        chk({tag, " flags hold"}, 32'(flags), 32'(efr));
        m_last = eid;
        m_freg = efr;
    endtask

    typedef struct {
        logic        p;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  op;
        logic        setf;
        int          bp;
        logic [15:0] d;
        logic [3:0]  rf;
        logic [3:0]  fr;
    } vec_t;

    initial begin
        vec_t        tbl[6];
        int          gc[$];
        logic        gid[$];
        logic        eg;
        logic [15:0] ra, rb, ed;
        logic [4:0]  rop;
        logic        rs, v0, v1, eid;
        logic [1:0]  pat;
        logic [3:0]  erf, efr;
        int          bp;

        tbl[0] = '{1'b0, 16'd5,      16'd3,      OP_ADD, 1'b1, 0, 16'd8,      4'b0000, 4'b0000};
        tbl[1] = '{1'b1, 16'd7,      16'd7,      OP_SUB, 1'b1, 0, 16'd0,      4'b0001, 4'b0001};
        tbl[2] = '{1'b1, 16'd9,      16'd7,      OP_SUB, 1'b0, 0, 16'd2,      4'b0000, 4'b0001};
        tbl[3] = '{1'b0, 16'h7FFF,   16'h0001,   OP_ADD, 1'b1, 0, 16'h8000,   4'b1010, 4'b1010};
        tbl[4] = '{1'b1, 16'h1234,   16'h00FF,   OP_XOR, 1'b0, 5, 16'h12CB,   4'b0000, 4'b1010};
        tbl[5] = '{1'b0, 16'hFFFF,   16'h0001,   OP_ADD, 1'b1, 0, 16'h0000,   4'b0101, 4'b0101};

        // Reset values
        #12;
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst rsp_id", 32'(rsp_id), 0);
        chk("rst rsp_data", 32'(rsp_data), 0);
        chk("rst rsp_flags", 32'(rsp_flags), 0);
        chk("rst flags", 32'(flags), 0);
        chk("rst ula", 32'({ula_a, ula_op}), 0);
        chk("rst ula_b", 32'(ula_b), 0);
        chk("rst readys", 32'({req1_ready, req0_ready}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            send(!tbl[i].p, tbl[i].p,
                 tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].setf,
                 tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].setf,
                 tbl[i].bp, tbl[i].p, tbl[i].d, tbl[i].rf, tbl[i].fr, $sformatf("vec%0d", i));
        end

        // Tie: both valid continuously, grants alternate and are 3 cycles apart
        req0_a = 16'd1; req0_b = 16'd2; req0_op = OP_ADD; req0_setf = 1'b0;
        req1_a = 16'd3; req1_b = 16'd4; req1_op = OP_SUB; req1_setf = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("tie onehot", 32'(req0_ready & req1_ready), 0);
                gc.push_back(c);
                gid.push_back(req1_ready);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie grant count", 32'(gc.size()), 4);
        eg = !m_last;
        for (int k = 0; k < gc.size() && k < 4; k++) begin
            chk($sformatf("tie cycle %0d", k), 32'(gc[k]), 32'(3 * k));
            chk($sformatf("tie id %0d", k), 32'(gid[k]), 32'(eg));
            eg = !eg;
        end
        m_last = !eg;
        repeat (3) @(negedge clk);

        // Reset while in EXEC
        req0_a = 16'h0F0F; req0_b = 16'h0101; req0_op = OP_ADD; req0_setf = 1'b1;
        req0_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("mid ready0", 32'(req0_ready), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst rsp_valid", 32'(rsp_valid), 0);
        chk("mid rst rsp_data", 32'(rsp_data), 0);
        chk("mid rst rsp_id_flags", 32'({rsp_id, rsp_flags}), 0);
        chk("mid rst flags", 32'(flags), 0);
        chk("mid rst ula", 32'({ula_a, ula_b}), 0);
        chk("mid rst ula_op", 32'(ula_op), 0);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        m_freg = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post rst no rsp", 32'(rsp_valid), 0);
        end
        send(1'b1, 1'b1, 16'h0010, 16'h0020, OP_ADD, 1'b1, 16'h0005, 16'h0001, OP_SUB, 1'b1,
             0, 1'b0, 16'h0030, 4'b0000, 4'b0000, "post rst tie");

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            pat = 2'($urandom_range(1, 3));
            v0  = pat[0];
            v1  = pat[1];
            eid = (v0 && v1) ? !m_last : v1;
            req0_a = 16'($urandom); req0_b = 16'($urandom);
            req0_op = 5'($urandom_range(0, 3)); req0_setf = 1'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom);
            req1_op = 5'($urandom_range(0, 3)); req1_setf = 1'($urandom);
            if (n % 8 == 0) begin req0_b = req0_a; req1_b = req1_a; end
            ra  = eid ? req1_a : req0_a;
            rb  = eid ? req1_b : req0_b;
            rop = eid ? req1_op : req0_op;
            rs  = eid ? req1_setf : req0_setf;
            ref_op(rop, ra, rb, ed, erf);
            efr = rs ? erf : m_freg;
            bp  = $urandom_range(0, 3);
            send(v0, v1, req0_a, req0_b, req0_op, req0_setf, req1_a, req1_b, req1_op, req1_setf,
                 bp, eid, ed, erf, efr, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
